digital_clk_alarm: RTL and testbench
====================================

Name: digital_clk_alarm

Overview:
- Parameterised time-of-day clock: a second prescaler drives a seconds/minutes/hours counter with runtime 12/24-hour display mode.
- Validated time load and alarm load.
- Alarm state machine with ring timeout and snooze.
- Sits between the system clock and the display/BCD driver; replaces the free-running 24 h counter with one that has prescaling, validation and alarm support.

Parameters:
- TICKS_PER_SEC, 100000000: clk_i cycles per second. Must be 2 or more.
- RING_SEC, 60: seconds the alarm rings before auto-stop. Must be 1 or more.
- SNOOZE_MIN, 5: snooze duration in minutes. Must be 1 or more.

Ports:
- clk_i  in  1  system clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous active-high reset.
- mode12_i  in  1  1 = 12-hour display, 0 = 24-hour display.
- set_i  in  1  one-cycle strobe; load time from hour_set_i/min_set_i/sec_set_i.
- hour_set_i  in  5  hour to load, always 24 h format, 0-23.
- min_set_i  in  6  minute to load, 0-59; shared by time load and alarm load.
- sec_set_i  in  6  second to load, 0-59.
- alarm_set_i  in  1  one-cycle strobe; load alarm hour/minute from hour_set_i/min_set_i.
- alarm_en_i  in  1  level; alarm armed.
- snooze_i  in  1  one-cycle strobe.
- stop_i  in  1  one-cycle strobe.
- sec_o  out  6  seconds, 0-59.
- min_o  out  6  minutes, 0-59.
- hour_o  out  5  0-23 in 24 h mode; 1-12 in 12 h mode.
- pm_o  out  1  1 when mode12_i=1 and internal hour is 12 or more; else 0.
- tick_o  out  1  one-cycle pulse on each counted second.
- set_err_o  out  1  one-cycle pulse when a load strobe carries out-of-range data.
- alarm_o  out  1  level; high while in RING.

Behaviour:
- Reset (async, immediate, no clock edge needed):
  - prescaler=0; time=00:00:00; alarm=00:00; FSM=IDLE.
  - tick_o, set_err_o, alarm_o = 0.
  - hour_o reads 0 in 24 h mode, 12 in 12 h mode.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1, width $clog2(TICKS_PER_SEC), then wraps to 0.
  - Tick condition = prescaler at TICKS_PER_SEC-1.
  - On that edge: time advances and the registered tick_o goes high for exactly one cycle.
- Counting (registered, updated on the tick edge):
  - sec 59->0 with min+1.
  - min 59->0 with hour+1.
  - hour 23->0.
  - Internal hour is always 0-23; no value 24 ever exists.
- Display mapping (combinational from the internal hour and mode12_i; follows mode12_i with no latency):
  - 0 -> 12 AM.
  - 1-11 -> same value, AM.
  - 12 -> 12 PM.
  - 13-23 -> h-12, PM.
- Time load (set_i):
  - Valid when hour<24, min<60, sec<60. Values appear on outputs the cycle after the strobe; prescaler cleared to 0.
  - set_i has priority over a coincident tick. That tick is discarded and tick_o stays 0.
  - Invalid load: time unchanged, prescaler unchanged, set_err_o pulses the next cycle.
- Alarm load (alarm_set_i):
  - Valid when hour<24, min<60; otherwise set_err_o pulses and the alarm registers are unchanged.
  - A valid alarm load in RING or SNOOZE forces IDLE.
  - set_i and alarm_set_i in the same cycle are evaluated independently; set_err_o pulses if either is invalid.
- Match event: a counted tick whose new time equals alarm_hour:alarm_min:00. A time load landing on that time is not a match.
- Alarm FSM (registered, 3 states):
  - IDLE: match with alarm_en_i=1 -> RING; ring counter loaded with RING_SEC.
  - RING:
    - alarm_o=1; ring counter decrements per tick.
    - stop_i -> IDLE.
    - else snooze_i -> SNOOZE, snooze counter loaded with SNOOZE_MIN*60.
    - Ring counter reaches 0 -> IDLE.
  - SNOOZE:
    - Counter decrements per tick; reaching 0 -> RING with ring counter reloaded.
    - stop_i -> IDLE; snooze_i ignored.
  - Priority:
    - alarm_en_i=0 forces IDLE next cycle from any state.
    - stop_i beats snooze_i in the same cycle.
    - A match while in RING or SNOOZE is ignored.
- alarm_o is registered and goes high on the same edge the time changes to the match time.

Test Plan (TICKS_PER_SEC=4, RING_SEC=3, SNOOZE_MIN=1):
- Release reset, idle 240 clocks -> tick_o pulses every 4th cycle; sec_o=1 after 4 clocks; min_o=1, sec_o=0 after 240 clocks.
- Time rollover and 12 h mapping:
  - set 23:59:58, mode12_i=0, wait 2 ticks -> 00:00:00, no value 24.
  - switch mode12_i=1 -> hour_o=12, pm_o=0 immediately.
  - set 13:00:00 -> hour_o=1, pm_o=1.
- Validation: set_i with hour 24 -> set_err_o high 1 cycle, time unchanged. set_i coincident with a tick -> loaded values shown, tick_o=0 that cycle.
- Ring timeout: alarm 07:30, set 07:29:59, alarm_en_i=1 -> alarm_o=1 at the 07:30:00 edge; alarm_o=0 after 3 further ticks. Setting the time directly to 07:30:00 -> no ring.
- Snooze and priority:
  - in RING, pulse snooze_i -> alarm_o=0; re-asserts exactly 60 ticks later.
  - stop_i and snooze_i in the same cycle -> IDLE, no re-ring.
- Asynchronous reset mid-ring: assert reset_i between clock edges -> alarm_o=0 and time=00:00:00 immediately; FSM=IDLE after release.

Source files
------------

// File: rtl/digital_clk_alarm.sv
// Time-of-day clock with second prescaler, 12/24 h display,
// validated time/alarm load and a ring/snooze alarm FSM.
module digital_clk_alarm #(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int RING_SEC      = 60,
    parameter int SNOOZE_MIN    = 5
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       mode12_i,
    input  logic       set_i,
    input  logic [4:0] hour_set_i,
    input  logic [5:0] min_set_i,
    input  logic [5:0] sec_set_i,
    input  logic       alarm_set_i,
    input  logic       alarm_en_i,
    input  logic       snooze_i,
    input  logic       stop_i,
    output logic [5:0] sec_o,
    output logic [5:0] min_o,
    output logic [4:0] hour_o,
    output logic       pm_o,
    output logic       tick_o,
    output logic       set_err_o,
    output logic       alarm_o
);

    localparam int PW  = $clog2(TICKS_PER_SEC);
    localparam int SNZ = SNOOZE_MIN * 60;
    localparam int RW  = $clog2(RING_SEC + 1);
    localparam int SW  = $clog2(SNZ + 1);
    localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    logic [PW-1:0] presc_q;
    logic [5:0]    sec_q, min_q, al_min_q;
    logic [4:0]    hour_q, al_hour_q;
    logic          tick_q, err_q;
    state_t        state_q, state_d;
    logic [RW-1:0] ring_q, ring_d;
    logic [SW-1:0] snz_q, snz_d;

    logic       set_ok, alarm_ok, do_set, do_alarm, tick, match;
    logic [5:0] sec_n, min_n;
    logic [4:0] hour_n;

    assign set_ok   = (hour_set_i < 5'd24) && (min_set_i < 6'd60)
                   && (sec_set_i < 6'd60);
    assign alarm_ok = (hour_set_i < 5'd24) && (min_set_i < 6'd60);
    assign do_set   = set_i && set_ok;
    assign do_alarm = alarm_set_i && alarm_ok;
    // A valid load swallows a coincident tick
    assign tick     = (presc_q == PMAX) && !do_set;

    always_comb begin
        sec_n  = sec_q + 6'd1;
        min_n  = min_q;
        hour_n = hour_q;
        if (sec_q == 6'd59) begin
            sec_n = 6'd0;
            min_n = min_q + 6'd1;
            if (min_q == 6'd59) begin
                min_n  = 6'd0;
                hour_n = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end
        end
    end

    assign match = tick && (hour_n == al_hour_q) && (min_n == al_min_q)
                && (sec_n == 6'd0);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            presc_q   <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            hour_q    <= '0;
            al_hour_q <= '0;
            al_min_q  <= '0;
            tick_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            tick_q <= tick;
            err_q  <= (set_i && !set_ok) || (alarm_set_i && !alarm_ok);
            if (do_set) begin
                presc_q <= '0;
                sec_q   <= sec_set_i;
                min_q   <= min_set_i;
                hour_q  <= hour_set_i;
            end else if (tick) begin
                presc_q <= '0;
                sec_q   <= sec_n;
                min_q   <= min_n;
                hour_q  <= hour_n;
            end else begin
                presc_q <= presc_q + PW'(1);
            end
            if (do_alarm) begin
                al_hour_q <= hour_set_i;
                al_min_q  <= min_set_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        snz_d   = snz_q;
        if (!alarm_en_i) begin
            state_d = IDLE;
        end else if (do_alarm && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (match) begin
                        state_d = RING;
                        ring_d  = RW'(RING_SEC);
                    end
                end
                RING: begin
                    if (stop_i) begin
                        state_d = IDLE;
                    end else if (snooze_i) begin
                        state_d = SNOOZE;
                        snz_d   = SW'(SNZ);
                    end else if (tick) begin
                        ring_d = ring_q - RW'(1);
                        if (ring_q == RW'(1)) state_d = IDLE;
                    end
                end
                SNOOZE: begin
                    if (stop_i) begin
                        state_d = IDLE;
                    end else if (tick) begin
                        snz_d = snz_q - SW'(1);
                        if (snz_q == SW'(1)) begin
                            state_d = RING;
                            ring_d  = RW'(RING_SEC);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            ring_q  <= '0;
            snz_q   <= '0;
        end else begin
            state_q <= state_d;
            ring_q  <= ring_d;
            snz_q   <= snz_d;
        end
    end

    always_comb begin
        hour_o = hour_q;
        if (mode12_i) begin
            if (hour_q == 5'd0)       hour_o = 5'd12;
            else if (hour_q > 5'd12)  hour_o = hour_q - 5'd12;
        end
    end

    assign pm_o      = mode12_i && (hour_q >= 5'd12);
    assign sec_o     = sec_q;
    assign min_o     = min_q;
    assign tick_o    = tick_q;
    assign set_err_o = err_q;
    assign alarm_o   = (state_q == RING);

endmodule

// File: tb/tb_digital_clk_alarm.sv
// Scoreboard bench for digital_clk_alarm with a 4-cycle second,
// 3 s ring and 1 min snooze.
module tb_digital_clk_alarm;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       mode12_i = 1'b0;
    logic       set_i = 1'b0;
    logic [4:0] hour_set_i = '0;
    logic [5:0] min_set_i = '0;
    logic [5:0] sec_set_i = '0;
    logic       alarm_set_i = 1'b0;
    logic       alarm_en_i = 1'b0;
    logic       snooze_i = 1'b0;
    logic       stop_i = 1'b0;
    logic [5:0] sec_o, min_o;
    logic [4:0] hour_o;
    logic       pm_o, tick_o, set_err_o, alarm_o;

    digital_clk_alarm #(
        .TICKS_PER_SEC(4),
        .RING_SEC(3),
        .SNOOZE_MIN(1)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .mode12_i(mode12_i),
        .set_i(set_i),
        .hour_set_i(hour_set_i),
        .min_set_i(min_set_i),
        .sec_set_i(sec_set_i),
        .alarm_set_i(alarm_set_i),
        .alarm_en_i(alarm_en_i),
        .snooze_i(snooze_i),
        .stop_i(stop_i),
        .sec_o(sec_o),
        .min_o(min_o),
        .hour_o(hour_o),
        .pm_o(pm_o),
        .tick_o(tick_o),
        .set_err_o(set_err_o),
        .alarm_o(alarm_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       pm;
        logic       al;
    } exp_t;

    exp_t obs;
    assign obs = {hour_o, min_o, sec_o, pm_o, alarm_o};

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    function automatic exp_t mk(input int h, m, s, pm, al);
        exp_t e;
        e.h = 5'(h);
        e.m = 6'(m);
        e.s = 6'(s);
        e.pm = 1'(pm);
        e.al = 1'(al);
        return e;
    endfunction

    task automatic cyc();
        @(negedge clk_i);
    endtask

    task automatic do_set(input int h, m, s);
        hour_set_i = 5'(h);
        min_set_i = 6'(m);
        sec_set_i = 6'(s);
        set_i = 1'b1;
        cyc();
        set_i = 1'b0;
    endtask

    task automatic do_alarm(input int h, m);
        hour_set_i = 5'(h);
        min_set_i = 6'(m);
        alarm_set_i = 1'b1;
        cyc();
        alarm_set_i = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset_i = 1'b1;
        #1;
        total++;
        if ({obs, tick_o, set_err_o} !== {mk(0, 0, 0, 0, 0), 2'b00}) begin
            bad++;
            $display("FAIL reset_state got %h want %h", obs, mk(0, 0, 0, 0, 0));
        end
        mode12_i = 1'b1;
        #1;
        total++;
        if ({hour_o, pm_o} !== {5'd12, 1'b0}) begin
            bad++;
            $display("FAIL reset_12h got h=%0d pm=%0d want h=12 pm=0", hour_o, pm_o);
        end
        mode12_i = 1'b0;
        cyc();
        reset_i = 1'b0;
    endtask

    task automatic test_count();
        exp_t e;
        for (int k = 1; k <= 60; k++) sb.push_back(mk(0, k / 60, k % 60, 0, 0));
        for (int i = 1; i <= 240; i++) begin
            cyc();
            total++;
            if (tick_o !== ((i % 4) == 0)) begin
                bad++;
                $display("FAIL tick_cadence cyc=%0d got %b want %b", i, tick_o, (i % 4) == 0);
            end
            if (tick_o === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (obs !== e) begin
                    bad++;
                    $display("FAIL count_time got %h want %h", obs, e);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL count_drain got %0d left want 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_rollover();
        exp_t e;
        mode12_i = 1'b0;
        do_set(23, 59, 58);
        sb.push_back(mk(23, 59, 58, 0, 0));
        e = sb.pop_front();
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL roll_load got %h want %h", obs, e);
        end
        sb.push_back(mk(23, 59, 59, 0, 0));
        sb.push_back(mk(0, 0, 0, 0, 0));
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            cyc();
            total++;
            if (hour_o > 5'd23) begin
                bad++;
                $display("FAIL roll_range got %0d want <24", hour_o);
            end
            if (tick_o === 1'b1) begin
                e = sb.pop_front();
                total++;
                if (obs !== e) begin
                    bad++;
                    $display("FAIL roll_time got %h want %h", obs, e);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL roll_timeout got %0d left want 0", sb.size());
        end
        sb.delete();
        mode12_i = 1'b1;
        #1;
        total++;
        if ({hour_o, pm_o} !== {5'd12, 1'b0}) begin
            bad++;
            $display("FAIL mid_12h got h=%0d pm=%0d want h=12 pm=0", hour_o, pm_o);
        end
        do_set(13, 0, 0);
        total++;
        if (obs !== mk(1, 0, 0, 1, 0)) begin
            bad++;
            $display("FAIL pm_map got %h want %h", obs, mk(1, 0, 0, 1, 0));
        end
        mode12_i = 1'b0;
    endtask

    task automatic test_validation();
        exp_t e;
        int c;
        bit err_seen;
        do_set(10, 20, 30);
        total++;
        if (obs !== mk(10, 20, 30, 0, 0)) begin
            bad++;
            $display("FAIL val_load got %h want %h", obs, mk(10, 20, 30, 0, 0));
        end
        do_set(24, 0, 0);
        total++;
        if ({set_err_o, obs} !== {1'b1, mk(10, 20, 30, 0, 0)}) begin
            bad++;
            $display("FAIL bad_hour got err=%b %h want err=1 %h", set_err_o, obs, mk(10, 20, 30, 0, 0));
        end
        sb.push_back(mk(10, 20, 31, 0, 0));
        c = 0;
        err_seen = 0;
        while (c < 10 && sb.size() > 0) begin
            cyc();
            c++;
            err_seen |= set_err_o;
            if (tick_o === 1'b1) begin
                e = sb.pop_front();
                total++;
                if ({c[3:0], obs} !== {4'd3, e}) begin
                    bad++;
                    $display("FAIL bad_presc got c=%0d %h want c=3 %h", c, obs, e);
                end
            end
        end
        total++;
        if ({err_seen, sb.size() == 0} !== 2'b01) begin
            bad++;
            $display("FAIL err_pulse got seen=%b left=%0d want seen=0 left=0", err_seen, sb.size());
        end
        sb.delete();
        cyc();
        cyc();
        cyc();
        do_set(5, 6, 7);
        total++;
        if ({tick_o, obs} !== {1'b0, mk(5, 6, 7, 0, 0)}) begin
            bad++;
            $display("FAIL set_vs_tick got t=%b %h want t=0 %h", tick_o, obs, mk(5, 6, 7, 0, 0));
        end
        sb.push_back(mk(5, 6, 8, 0, 0));
        c = 0;
        while (c < 10 && sb.size() > 0) begin
            cyc();
            c++;
            if (tick_o === 1'b1) begin
                e = sb.pop_front();
                total++;
                if ({c[3:0], obs} !== {4'd4, e}) begin
                    bad++;
                    $display("FAIL post_set_tick got c=%0d %h want c=4 %h", c, obs, e);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL post_set_timeout got %0d left want 0", sb.size());
        end
        sb.delete();
        do_alarm(3, 60);
        total++;
        if (set_err_o !== 1'b1) begin
            bad++;
            $display("FAIL bad_alarm got %b want 1", set_err_o);
        end
    endtask

    task automatic test_ring();
        exp_t e;
        alarm_en_i = 1'b1;
        do_alarm(7, 30);
        do_set(7, 29, 59);
        sb.push_back(mk(7, 30, 0, 0, 1));
        sb.push_back(mk(7, 30, 1, 0, 1));
        sb.push_back(mk(7, 30, 2, 0, 1));
        sb.push_back(mk(7, 30, 3, 0, 0));
        for (int c = 0; c < 24 && sb.size() > 0; c++) begin
            cyc();
            if (tick_o === 1'b1) begin
                e = sb.pop_front();
                total++;
                if (obs !== e) begin
                    bad++;
                    $display("FAIL ring_seq got %h want %h", obs, e);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL ring_timeout got %0d left want 0", sb.size());
        end
        sb.delete();
        do_set(7, 30, 0);
        sb.push_back(mk(7, 30, 1, 0, 0));
        for (int c = 0; c < 8 && sb.size() > 0; c++) begin
            cyc();
            total++;
            if (alarm_o !== 1'b0) begin
                bad++;
                $display("FAIL load_no_ring got %b want 0", alarm_o);
            end
            if (tick_o === 1'b1) begin
                e = sb.pop_front();
                total++;
                if (obs !== e) begin
                    bad++;
                    $display("FAIL load_tick got %h want %h", obs, e);
                end
            end
        end
        sb.delete();
    endtask

    task automatic test_snooze();
        exp_t e;
        int n;
        bit seen;
        do_set(7, 29, 59);
        repeat (4) cyc();
        total++;
        if (alarm_o !== 1'b1) begin
            bad++;
            $display("FAIL snz_ring got %b want 1", alarm_o);
        end
        snooze_i = 1'b1;
        cyc();
        snooze_i = 1'b0;
        total++;
        if (alarm_o !== 1'b0) begin
            bad++;
            $display("FAIL snz_quiet got %b want 0", alarm_o);
        end
        sb.push_back(mk(7, 31, 0, 0, 1));
        n = 0;
        for (int c = 0; c < 300 && sb.size() > 0; c++) begin
            cyc();
            if (tick_o === 1'b1) begin
                n++;
                if (n < 60) begin
                    total++;
                    if (alarm_o !== 1'b0) begin
                        bad++;
                        $display("FAIL snz_early tick=%0d got %b want 0", n, alarm_o);
                    end
                end else begin
                    e = sb.pop_front();
                    total++;
                    if (obs !== e) begin
                        bad++;
                        $display("FAIL snz_rering got %h want %h", obs, e);
                    end
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL snz_timeout got %0d left want 0", sb.size());
        end
        sb.delete();
        stop_i = 1'b1;
        snooze_i = 1'b1;
        cyc();
        stop_i = 1'b0;
        snooze_i = 1'b0;
        total++;
        if (alarm_o !== 1'b0) begin
            bad++;
            $display("FAIL stop_wins got %b want 0", alarm_o);
        end
        seen = 0;
        repeat (260) begin
            cyc();
            seen |= alarm_o;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL stop_no_rering got %b want 0", seen);
        end
    endtask

    task automatic test_async_reset();
        do_set(7, 29, 59);
        repeat (4) cyc();
        total++;
        if (alarm_o !== 1'b1) begin
            bad++;
            $display("FAIL ar_ring got %b want 1", alarm_o);
        end
        #2 reset_i = 1'b1;
        #1;
        total++;
        if (obs !== mk(0, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL ar_immediate got %h want %h", obs, mk(0, 0, 0, 0, 0));
        end
        #1 reset_i = 1'b0;
        repeat (8) cyc();
        total++;
        if (obs !== mk(0, 0, 2, 0, 0)) begin
            bad++;
            $display("FAIL ar_after got %h want %h", obs, mk(0, 0, 2, 0, 0));
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_rollover();
        test_validation();
        test_ring();
        test_snooze();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
